pulse_test_sequencer: RTL and testbench

Sequences repeated trials of the pulse tester and reduces its 57-bit result records into pass/fail statistics. It strobes the tester's start input once per trial and pops one record per trial from the tester's result FIFO. Each record is classified against delay and width tolerances. Counters are exported to the host/status logic, so software reads totals instead of draining raw records.

---
 rtl/pulse_seq_pkg.sv | 29 ++
 rtl/pulse_record_classifier.sv | 36 +++
 rtl/pulse_test_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pulse_test_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse test sequencer.
// Contents: FSM state encoding, result-record field layout, timeout tag,
// counter width and a saturating-increment helper.
package pulse_seq_pkg;

    localparam int CNT_W       = 16;
    localparam int REC_W       = 57;
    localparam int REC_TAG_MSB = 56;
    localparam int DELAY_LSB   = 24;
    localparam int DELAY_W     = 32;
    localparam int ERR_W       = 24;

    localparam logic [1:0] TIMEOUT_TAG = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREDRAIN,
        ST_ARM,
        ST_WAIT,
        ST_READ,
        ST_EVAL,
        ST_DONE
    } seq_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pulse_record_classifier.sv
// Combinational classifier for one 57-bit tester result record.
// Ports:
//   rec_data   in  57  raw record from the tester FIFO
//   is_timeout out 1   record carries the timeout tag
//   delay_fail out 1   delay exceeds DELAY_MAX (never set for timeouts)
//   width_fail out 1   |width error| exceeds WIDTH_TOL (never set for timeouts)
//   delay      out 32  delay field of the record
module pulse_record_classifier
    import pulse_seq_pkg::*;
#(
    parameter logic [31:0] DELAY_MAX = 32'd64,
    parameter logic [23:0] WIDTH_TOL = 24'd8
) (
    input  logic [REC_W-1:0]   rec_data,
    output logic               is_timeout,
    output logic               delay_fail,
    output logic               width_fail,
    output logic [DELAY_W-1:0] delay
);

    logic [ERR_W-1:0] err;
    logic [ERR_W:0]   err_ext;
    logic [ERR_W:0]   err_mag;

    assign is_timeout = (rec_data[REC_TAG_MSB -: 2] == TIMEOUT_TAG);
    assign delay      = rec_data[DELAY_LSB +: DELAY_W];
    assign err        = rec_data[ERR_W-1:0];

    // One extra bit so the most negative error (-2^23) has a representable magnitude.
    assign err_ext = {err[ERR_W-1], err};
    assign err_mag = err_ext[ERR_W] ? (~err_ext + {{ERR_W{1'b0}}, 1'b1}) : err_ext;

    assign delay_fail = !is_timeout && (delay > DELAY_MAX);
    assign width_fail = !is_timeout && (err_mag > {1'b0, WIDTH_TOL});

endmodule

// File: rtl/pulse_test_sequencer.sv
// Runs repeated pulse-tester trials and reduces result records to counters.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, abort      run request / run abort
//   num_trials [16]   trials per run, latched on accepted start
//   busy, done        run in progress / last run completed normally
//   tester_start      one-cycle trial strobe to the tester
//   rec_data [57], rec_empty, rec_rd_en   tester result FIFO read side
//   pass_cnt, fail_delay_cnt, fail_width_cnt, timeout_cnt [16]  saturating counters
//   max_delay [32]    largest delay among non-timeout records this run
//
// state    | meaning
// IDLE     | waiting for start
// PREDRAIN | pop stale records until FIFO seen empty two cycles in a row
// ARM      | tester_start high for this cycle
// WAIT     | waiting for the trial's record
// READ     | rec_rd_en high; data valid next cycle
// EVAL     | classify record, update counters, pick next trial or finish
// DONE     | raise done, drop busy
module pulse_test_sequencer
    import pulse_seq_pkg::*;
#(
    parameter logic [31:0] DELAY_MAX = 32'd64,
    parameter logic [23:0] WIDTH_TOL = 24'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_trials,
    output logic             busy,
    output logic             done,
    output logic             tester_start,
    input  logic [REC_W-1:0] rec_data,
    input  logic             rec_empty,
    output logic             rec_rd_en,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_delay_cnt,
    output logic [CNT_W-1:0] fail_width_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [31:0]      max_delay
);

    seq_state_t       state;
    logic [CNT_W-1:0] trials_q;
    logic [CNT_W-1:0] trial_cnt;
    logic [CNT_W-1:0] trial_next;
    logic             empty_seen;

    logic             is_timeout;
    logic             delay_fail;
    logic             width_fail;
    logic [31:0]      rec_delay;

    pulse_record_classifier #(
        .DELAY_MAX (DELAY_MAX),
        .WIDTH_TOL (WIDTH_TOL)
    ) u_classifier (
        .rec_data   (rec_data),
        .is_timeout (is_timeout),
        .delay_fail (delay_fail),
        .width_fail (width_fail),
        .delay      (rec_delay)
    );

    // Never wraps: the run ends on exact equality with the latched count.
    assign trial_next = trial_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            tester_start   <= 1'b0;
            rec_rd_en      <= 1'b0;
            pass_cnt       <= '0;
            fail_delay_cnt <= '0;
            fail_width_cnt <= '0;
            timeout_cnt    <= '0;
            max_delay      <= '0;
            trials_q       <= '0;
            trial_cnt      <= '0;
            empty_seen     <= 1'b0;
        end else begin
            tester_start <= 1'b0;
            rec_rd_en    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        pass_cnt       <= '0;
                        fail_delay_cnt <= '0;
                        fail_width_cnt <= '0;
                        timeout_cnt    <= '0;
                        max_delay      <= '0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                        trials_q       <= num_trials;
                        trial_cnt      <= '0;
                        empty_seen     <= 1'b0;
                        state          <= ST_PREDRAIN;
                    end
                end
                ST_PREDRAIN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (rec_empty) begin
                        if (empty_seen) begin
                            tester_start <= (trials_q != '0);
                            state        <= (trials_q == '0) ? ST_DONE : ST_ARM;
                        end else begin
                            empty_seen <= 1'b1;
                        end
                    end else begin
                        // Pop every other cycle so the flag can settle after each pop.
                        empty_seen <= 1'b0;
                        rec_rd_en  <= !rec_rd_en;
                    end
                end
                ST_ARM: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (!rec_empty) begin
                        rec_rd_en <= 1'b1;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_EVAL;
                end
                ST_EVAL: begin
                    trial_cnt <= trial_next;
                    if (is_timeout) begin
                        timeout_cnt <= sat_inc(timeout_cnt);
                    end else begin
                        if (delay_fail)
                            fail_delay_cnt <= sat_inc(fail_delay_cnt);
                        if (width_fail)
                            fail_width_cnt <= sat_inc(fail_width_cnt);
                        if (!delay_fail && !width_fail)
                            pass_cnt <= sat_inc(pass_cnt);
                        if (rec_delay > max_delay)
                            max_delay <= rec_delay;
                    end
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (trial_next == trials_q) begin
                        state <= ST_DONE;
                    end else begin
                        tester_start <= 1'b1;
                        state        <= ST_ARM;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_test_sequencer.sv
// Scoreboard bench for pulse_test_sequencer: a tester/FIFO model answers each
// tester_start with a queued record after a random latency; expected run
// results are pushed when a run is issued and checked when busy falls.
module tb_pulse_test_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_trials = 16'd0;
    logic        busy, done, tester_start, rec_rd_en;
    logic [56:0] rec_data = '0;
    logic        rec_empty = 1'b1;
    logic [15:0] pass_cnt, fail_delay_cnt, fail_width_cnt, timeout_cnt;
    logic [31:0] max_delay;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_test_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .num_trials     (num_trials),
        .busy           (busy),
        .done           (done),
        .tester_start   (tester_start),
        .rec_data       (rec_data),
        .rec_empty      (rec_empty),
        .rec_rd_en      (rec_rd_en),
        .pass_cnt       (pass_cnt),
        .fail_delay_cnt (fail_delay_cnt),
        .fail_width_cnt (fail_width_cnt),
        .timeout_cnt    (timeout_cnt),
        .max_delay      (max_delay)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [56:0] mk(input logic [31:0] d, input logic [23:0] er);
        return {1'b0, d, er};
    endfunction

    function automatic logic [56:0] rand_rec();
        int sel;
        logic [31:0] d;
        logic [23:0] er;
        sel = $urandom_range(9, 0);
        if (sel == 0) return {2'b11, 23'($urandom), 32'($urandom)};
        d  = (sel == 1) ? $urandom : 32'($urandom_range(80, 48));
        er = (sel == 2) ? 24'h800000 : 24'($urandom_range(12, 0));
        if (sel > 2 && $urandom_range(1, 0) == 1) er = 24'd0 - er;
        return {1'b0, d, er};
    endfunction

    // ---------------- tester + result FIFO model ----------------
    typedef struct { int due; logic [56:0] data; } pend_t;
    logic [56:0] fifo_q[$];
    logic [56:0] tester_q[$];
    logic [56:0] inject_q[$];
    logic [56:0] run_recs[$];
    pend_t       pend_q[$];
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 5;

    always @(negedge clk) begin
        pend_t p;
        cyc++;
        if (!rst_n) begin
            fifo_q.delete();
            pend_q.delete();
            rec_empty = 1'b1;
        end else begin
            if (rec_rd_en) begin
                chk("rd_en_while_empty", fifo_q.size() == 0, 0);
                if (fifo_q.size() > 0) rec_data = fifo_q.pop_front();
            end
            if (tester_start) begin
                p.due  = cyc + int'($urandom_range(lat_max, lat_min));
                p.data = (tester_q.size() > 0) ? tester_q.pop_front() : mk(32'd1, 24'd0);
                pend_q.push_back(p);
            end
            while (inject_q.size() > 0) fifo_q.push_back(inject_q.pop_front());
            while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                fifo_q.push_back(p.data);
            end
            rec_empty = (fifo_q.size() == 0);
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit     dn;
        int     pass, fd, fw, to;
        longint maxd;
        int     pulses;
    } exp_t;
    exp_t sb_q[$];

    function automatic exp_t model(input int n_eval, input int pulses, input bit dn);
        exp_t e;
        e = '{default: 0};
        e.dn = dn;
        e.pulses = pulses;
        for (int i = 0; i < n_eval; i++) begin
            logic [56:0] r;
            longint d;
            int ev, mag;
            bit df, wf;
            r = run_recs[i];
            if (r[56:55] == 2'b11) begin
                e.to++;
            end else begin
                d   = r[55:24];
                ev  = $signed(r[23:0]);
                mag = (ev < 0) ? -ev : ev;
                df  = d > 64;
                wf  = mag > 8;
                if (df) e.fd++;
                if (wf) e.fw++;
                if (!df && !wf) e.pass++;
                if (d > e.maxd) e.maxd = d;
            end
        end
        return e;
    endfunction

    bit busy_prev = 1'b0;
    int pulses_run = 0;
    int last_pulse = 0;
    int mcyc = 0;

    always @(negedge clk) begin
        exp_t e;
        mcyc++;
        if (!rst_n) begin
            busy_prev  = 1'b0;
            pulses_run = 0;
        end else begin
            if (busy && !busy_prev) pulses_run = 0;
            if (tester_start) begin
                if (pulses_run > 0) chk("pulse_gap_ge4", (mcyc - last_pulse) >= 4, 1);
                pulses_run++;
                last_pulse = mcyc;
            end
            if (!busy && busy_prev) begin
                chk("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("done",           done,           e.dn);
                    chk("pass_cnt",       pass_cnt,       e.pass);
                    chk("fail_delay_cnt", fail_delay_cnt, e.fd);
                    chk("fail_width_cnt", fail_width_cnt, e.fw);
                    chk("timeout_cnt",    timeout_cnt,    e.to);
                    chk("max_delay",      max_delay,      e.maxd);
                    chk("tester_pulses",  pulses_run,     e.pulses);
                end
            end
            busy_prev = busy;
        end
    end

    // ---------------- stimulus ----------------
    // abort_at: abort in WAIT after that many strobes; rst_at: async reset in WAIT after that many.
    task automatic run(input int n, input int abort_at, input int rst_at);
        int k;
        int p;
        bit finished;
        tester_q = run_recs;
        if (rst_at == 0) begin
            if (abort_at > 0) sb_q.push_back(model(abort_at - 1, abort_at, 1'b0));
            else              sb_q.push_back(model(n, n, 1'b1));
        end
        @(negedge clk);
        num_trials = 16'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_trials = 16'($urandom);
        chk("busy_after_start", busy, 1);
        chk("no_tstart_t1", tester_start, 0);
        @(negedge clk);
        chk("no_tstart_t2", tester_start, 0);
        k = 2;
        p = 0;
        finished = 1'b0;
        while (k < 3000) begin
            @(negedge clk);
            k++;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (tester_start) begin
                p++;
                chk("fifo_drained_at_arm", fifo_q.size(), 0);
                if (p == abort_at) begin
                    @(posedge clk); #1 abort = 1'b1;
                    @(posedge clk); #1 abort = 1'b0;
                end
                if (p == rst_at) begin
                    @(posedge clk); #1 rst_n = 1'b0;
                    #1;
                    chk("arst_busy",      busy,           0);
                    chk("arst_done",      done,           0);
                    chk("arst_tstart",    tester_start,   0);
                    chk("arst_rd_en",     rec_rd_en,      0);
                    chk("arst_pass",      pass_cnt,       0);
                    chk("arst_max_delay", max_delay,      0);
                    chk("arst_fdelay",    fail_delay_cnt, 0);
                    @(negedge clk); @(negedge clk);
                    rst_n = 1'b1;
                    finished = 1'b1;
                    break;
                end
            end
        end
        chk("run_ended", finished, 1);
        if (n == 0 && abort_at == 0 && rst_at == 0) chk("zero_trials_done_le4", (k <= 4) && done, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",      busy,           0);
        chk("rst_done",      done,           0);
        chk("rst_tstart",    tester_start,   0);
        chk("rst_rd_en",     rec_rd_en,      0);
        chk("rst_pass",      pass_cnt,       0);
        chk("rst_fdelay",    fail_delay_cnt, 0);
        chk("rst_fwidth",    fail_width_cnt, 0);
        chk("rst_timeout",   timeout_cnt,    0);
        chk("rst_max_delay", max_delay,      0);
        rst_n = 1'b1;
        @(negedge clk);

        run_recs.delete();
        run_recs.push_back(mk(32'd10, 24'd0));
        run_recs.push_back(mk(32'd20, 24'd3));
        run_recs.push_back(mk(32'd30, 24'hFFFFFB));
        run(3, 0, 0);

        run_recs.delete();
        run_recs.push_back(mk(32'd65, 24'hFFFFF7));
        run(1, 0, 0);

        run_recs.delete();
        run_recs.push_back(mk(32'd40, 24'd1));
        run_recs.push_back({2'b11, 55'd0});
        run_recs.push_back(mk(32'd5, 24'd0));
        run(3, 0, 0);

        run_recs.delete();
        run_recs.push_back(mk(32'd64, 24'd8));
        run_recs.push_back(mk(32'd64, 24'hFFFFF8));
        run_recs.push_back(mk(32'd0, 24'h800000));
        run_recs.push_back(mk(32'd65, 24'd9));
        run(4, 0, 0);

        inject_q.push_back(mk(32'd100, 24'h000100));
        inject_q.push_back(mk(32'd200, 24'h000100));
        repeat (3) @(negedge clk);
        run_recs.delete();
        run_recs.push_back(mk(32'd12, 24'd2));
        run(1, 0, 0);

        lat_min = 8;
        lat_max = 8;
        run_recs.delete();
        run_recs.push_back(mk(32'd11, 24'd0));
        run_recs.push_back(mk(32'd22, 24'd0));
        run_recs.push_back({2'b11, 55'd0});
        run_recs.push_back(mk(32'd1, 24'd0));
        run_recs.push_back(mk(32'd1, 24'd0));
        run(5, 3, 0);
        repeat (20) @(negedge clk);
        chk("held_pass_after_abort", pass_cnt, 2);
        chk("held_done_after_abort", done, 0);
        chk("held_busy_after_abort", busy, 0);
        lat_min = 1;
        lat_max = 5;
        run_recs.delete();
        run_recs.push_back(mk(32'd7, 24'hFFFFFF));
        run(1, 0, 0);

        run_recs.delete();
        run(0, 0, 0);

        repeat (25) begin
            int n;
            n = $urandom_range(6, 1);
            run_recs.delete();
            for (int i = 0; i < n; i++) run_recs.push_back(rand_rec());
            run(n, 0, 0);
        end

        lat_min = 10;
        lat_max = 10;
        run_recs.delete();
        run_recs.push_back(mk(32'd33, 24'd0));
        run_recs.push_back(mk(32'd44, 24'd0));
        run_recs.push_back(mk(32'd55, 24'd0));
        run(3, 0, 2);
        lat_min = 1;
        lat_max = 5;
        run_recs.delete();
        run_recs.push_back(mk(32'd70, 24'd2));
        run_recs.push_back(mk(32'd3, 24'd0));
        run(2, 0, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
